fact_engine: RTL and testbench
==============================

# fact_engine

Self-contained, parametrised factorial unit: integrated control FSM, down-counter, iterative multiplier and result register in one block. It computes N! for an unsigned N over a level GO/DONE handshake. It replaces the separate datapath/controller pair in the lab design as the single instance a top level or testbench drives. Result width, operand width and overflow handling are configurable.

## Interface
- WIDTH, 32, result/product width in bits (>= 8)
- NWIDTH, 5, width of operand N; counter is NWIDTH bits
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- GO  in  1  start request; level-sensitive, sampled only in IDLE and DONE
- N  in  NWIDTH  operand; captured on the edge that accepts GO
- BUSY  out  1  high while iterating (state MUL)
- DONE  out  1  high while result valid (state DONE)
- RESULT  out  WIDTH  N! when DONE=1, else 0
- OVF  out  1  overflow flag, valid when DONE=1, else 0

## Operation
- Registers: state, CNT[NWIDTH-1:0], PROD[WIDTH-1:0], OVF_R (sticky).
- Reset (RST=1 at an edge): state<=IDLE, CNT<=0, PROD<=0, OVF_R<=0; BUSY=DONE=OVF=0, RESULT=0. Reset overrides everything, including mid-computation.
- IDLE: GO=1 -> CNT<=N, PROD<=1, OVF_R<=0, state<=MUL. GO=0 -> stay.
- MUL: CNT>1 -> PROD<=PROD*CNT (product formed at WIDTH+NWIDTH bits), CNT<=CNT-1. CNT<=1 -> state<=DONE, registers hold. GO ignored; N changes ignored.
- DONE: RESULT=PROD, DONE=1, OVF=OVF_R. GO=0 -> state<=IDLE. GO=1 -> stay in DONE with no auto-restart. A new run requires GO to drop, then rise.
- N=0 and N=1 both yield RESULT=1.
- Outputs RESULT/OVF/BUSY/DONE are decoded from registered state only (Moore); no combinational path from GO or N to any output.

## Timing
- Edge e0 accepts GO in IDLE. DONE rises after edge e_max(N,1): latency max(N,1) cycles. BUSY is high for exactly max(N,1) cycles.
- One multiply per cycle. Multiplier is single-cycle combinational WIDTH x NWIDTH.
- Minimum back-to-back period: latency + 1 (DONE) + 1 (IDLE, GO low) cycles.
- RST asserted during MUL or DONE: next cycle IDLE with all outputs 0. The aborted run produces no DONE.

## Configuration
- Macro FACT_OVF_EN.
- Defined: if upper NWIDTH bits of the extended product are nonzero, or OVF_R is already set, then PROD<={WIDTH{1'b1}} (saturate) and OVF_R<=1. Iteration continues to fixed latency. Once saturated, PROD stays all-ones.
- Undefined: PROD takes the low WIDTH bits (mod 2^WIDTH). OVF is tied to 0 and no OVF_R logic is generated.

## Test plan
- Reset, then GO=1 with N=5 (WIDTH=32) -> BUSY for 5 cycles, then DONE=1, RESULT=120, OVF=0. GO held high -> DONE stays 1. GO low -> IDLE next cycle, RESULT=0.
- N=0, then N=1 -> each DONE after 1 cycle, RESULT=1.
- N=12, WIDTH=32 -> RESULT=479001600, OVF=0, latency 12.
- N=13, WIDTH=32, FACT_OVF_EN defined -> RESULT=0xFFFFFFFF, OVF=1. Macro undefined -> RESULT=1932053504, OVF=0. Latency 13 in both builds.
- N=10; assert RST for 1 cycle on the 4th MUL cycle -> IDLE, all outputs 0, no DONE pulse. A new GO with N=4 -> RESULT=24.
- N=6 started, then during MUL toggle GO and change N to 3 -> ignored, RESULT=720.

Source files
------------

// File: rtl/fact_engine.sv
// Iterative factorial unit: GO/DONE level handshake, one multiply per cycle.
// Optional saturation with sticky overflow when FACT_OVF_EN is defined.
`timescale 1ns/1ps
module fact_engine #(
  parameter int WIDTH  = 32,
  parameter int NWIDTH = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              GO,
  input  logic [NWIDTH-1:0] N,
  output logic              BUSY,
  output logic              DONE,
  output logic [WIDTH-1:0]  RESULT,
  output logic              OVF
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t            state;
  logic [NWIDTH-1:0] cnt;
  logic [WIDTH-1:0]  prod;
  logic              busy_r;
  logic              done_r;

  logic [WIDTH+NWIDTH-1:0] prod_ext;
  assign prod_ext = {{NWIDTH{1'b0}}, prod} * {{WIDTH{1'b0}}, cnt};

`ifdef FACT_OVF_EN
  logic ovf_r;
  logic sat;
  // Once any step spills past WIDTH bits the result stays pinned at all-ones.
  assign sat = ovf_r || (|prod_ext[WIDTH+NWIDTH-1:WIDTH]);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      cnt    <= '0;
      prod   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef FACT_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (GO) begin
            cnt    <= N;
            prod   <= WIDTH'(1);
            state  <= S_MUL;
            busy_r <= 1'b1;
`ifdef FACT_OVF_EN
            ovf_r  <= 1'b0;
`endif
          end
        end
        S_MUL: begin
          if (cnt > NWIDTH'(1)) begin
            cnt <= cnt - NWIDTH'(1);
`ifdef FACT_OVF_EN
            if (sat) begin
              prod  <= {WIDTH{1'b1}};
              ovf_r <= 1'b1;
            end else begin
              prod  <= prod_ext[WIDTH-1:0];
            end
`else
            prod <= prod_ext[WIDTH-1:0];
`endif
          end else begin
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        S_DONE: begin
          // No auto-restart: GO must drop before another run is accepted.
          if (!GO) begin
            state  <= S_IDLE;
            done_r <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY   = busy_r;
  assign DONE   = done_r;
  assign RESULT = done_r ? prod : '0;
`ifdef FACT_OVF_EN
  assign OVF    = done_r & ovf_r;
`else
  assign OVF    = 1'b0;
`endif

endmodule

// File: tb/tb_fact_engine.sv
// Directed bench for fact_engine: scoreboard queue of expected runs, checked on DONE.
`timescale 1ns/1ps
module tb_fact_engine;
  localparam int WIDTH  = 32;
  localparam int NWIDTH = 5;

  logic              CLK = 1'b0;
  logic              RST;
  logic              GO;
  logic [NWIDTH-1:0] N;
  logic              BUSY;
  logic              DONE;
  logic [WIDTH-1:0]  RESULT;
  logic              OVF;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             ovf;
    int               lat;
    string            tag;
  } exp_t;

  exp_t sb[$];

  fact_engine #(.WIDTH(WIDTH), .NWIDTH(NWIDTH)) dut (
    .CLK(CLK), .RST(RST), .GO(GO), .N(N),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"},   longint'(BUSY),   0);
    chk({tag, " done"},   longint'(DONE),   0);
    chk({tag, " result"}, longint'(RESULT), 0);
    chk({tag, " ovf"},    longint'(OVF),    0);
  endtask

  // Drive GO/N at a falling edge; the following rising edge is e0.
  task automatic launch(input int n, input logic [WIDTH-1:0] res, input logic ovf,
                        input string tag, input bit push);
    exp_t e;
    @(negedge CLK);
    N  = NWIDTH'(n);
    GO = 1'b1;
    if (push) begin
      e.res = res;
      e.ovf = ovf;
      e.lat = (n < 1) ? 1 : n;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  // Count edges from e0 until DONE, optionally wiggling GO/N while busy.
  task automatic wait_done(input bit wiggle);
    exp_t e;
    int   k = 0;
    int   busy_cnt = 0;
    @(negedge CLK);
    while (!DONE && k < 200) begin
      if (BUSY) busy_cnt++;
      if (wiggle) begin
        GO = ~GO;
        N  = NWIDTH'(3);
      end
      @(negedge CLK);
      k++;
    end
    if (sb.size() == 0) begin
      chk("scoreboard empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, " latency"},   k,                e.lat);
      chk({e.tag, " busy_cyc"},  busy_cnt,         e.lat);
      chk({e.tag, " result"},    longint'(RESULT), longint'(e.res));
      chk({e.tag, " ovf"},       longint'(OVF),    longint'(e.ovf));
      chk({e.tag, " busy_low"},  longint'(BUSY),   0);
    end
  endtask

  task automatic release_go(input string tag);
    @(negedge CLK);
    GO = 1'b0;
    @(negedge CLK);
    chk_idle({tag, " back_idle"});
  endtask

  initial begin
    int seen_done;
    RST = 1'b1;
    GO  = 1'b0;
    N   = '0;
    repeat (2) @(negedge CLK);
    chk_idle("reset");
    RST = 1'b0;
    @(negedge CLK);
    chk_idle("post_reset");

    // 5! with GO held through DONE
    launch(5, 32'd120, 1'b0, "n5", 1'b1);
    wait_done(1'b0);
    @(negedge CLK);
    chk("n5 hold done", longint'(DONE), 1);
    @(negedge CLK);
    chk("n5 hold done2", longint'(DONE), 1);
    chk("n5 hold result", longint'(RESULT), 120);
    release_go("n5");

    launch(0, 32'd1, 1'b0, "n0", 1'b1);
    wait_done(1'b0);
    release_go("n0");

    launch(1, 32'd1, 1'b0, "n1", 1'b1);
    wait_done(1'b0);
    release_go("n1");

    launch(12, 32'd479001600, 1'b0, "n12", 1'b1);
    wait_done(1'b0);
    release_go("n12");

`ifdef FACT_OVF_EN
    launch(13, 32'hFFFF_FFFF, 1'b1, "n13", 1'b1);
`else
    launch(13, 32'd1932053504, 1'b0, "n13", 1'b1);
`endif
    wait_done(1'b0);
    release_go("n13");

    // Abort N=10 on the 4th MUL cycle; no DONE may follow.
    launch(10, '0, 1'b0, "abort", 1'b0);
    repeat (4) @(negedge CLK);
    chk("abort busy_before", longint'(BUSY), 1);
    RST = 1'b1;
    GO  = 1'b0;
    @(negedge CLK);
    chk_idle("abort");
    RST = 1'b0;
    seen_done = 0;
    repeat (15) begin
      @(negedge CLK);
      if (DONE || BUSY) seen_done++;
    end
    chk("abort no_done", seen_done, 0);

    launch(4, 32'd24, 1'b0, "n4", 1'b1);
    wait_done(1'b0);
    release_go("n4");

    // GO toggling and N changes during MUL must not disturb the run
    launch(6, 32'd720, 1'b0, "n6_wiggle", 1'b1);
    wait_done(1'b1);
    release_go("n6_wiggle");

    chk("scoreboard drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
